alu_mdu: RTL and testbench

//  Parametrised execute-stage datapath: a combinational ALU plus an iterative multiply/divide unit (MDU).
//  The MDU holds architectural HI/LO registers and a Busy flag for pipeline stall logic.
//  ALU results are same-cycle. MDU results land in HI/LO after a fixed multi-cycle latency.

---
 rtl/alu_mdu_if.sv | 29 ++
 rtl/alu_mdu.sv | 168 ++++++++++++++++
 tb/tb_alu_mdu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Execute-stage bus for alu_mdu: ALU operands/controls, MDU request, and all results.
// The master drives operands and requests; the slave (alu_mdu) returns results and status.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]         SrcA;
  logic [WIDTH-1:0]         SrcB;
  logic [3:0]               ALUControl;
  logic [$clog2(WIDTH)-1:0] shamt;
  logic                     Start;
  logic [2:0]               MDUOp;
  logic [WIDTH-1:0]         ALUResult;
  logic                     Zero;
  logic                     GreaterZero;
  logic                     LessZero;
  logic                     Busy;
  logic [WIDTH-1:0]         HI;
  logic [WIDTH-1:0]         LO;

  modport master (
    output SrcA, SrcB, ALUControl, shamt, Start, MDUOp,
    input  ALUResult, Zero, GreaterZero, LessZero, Busy, HI, LO
  );

  modport slave (
    input  SrcA, SrcB, ALUControl, shamt, Start, MDUOp,
    output ALUResult, Zero, GreaterZero, LessZero, Busy, HI, LO
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage datapath: combinational ALU plus fixed-latency multiply/divide unit with HI/LO.
// Optional feature macro MDU_MADD_EN enables madd/msub accumulate into {HI,LO}.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_mdu_if.slave    bus
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (bus.ALUControl)
      4'd0:    alu_res = bus.SrcA + bus.SrcB;
      4'd1:    alu_res = bus.SrcA - bus.SrcB;
      4'd2:    alu_res = bus.SrcA ^ bus.SrcB;
      4'd3:    alu_res = bus.SrcA | bus.SrcB;
      4'd4:    alu_res = bus.SrcA & bus.SrcB;
      4'd5:    alu_res = bus.SrcB << bus.shamt;
      4'd6:    alu_res = bus.SrcB >> bus.shamt;
      4'd7:    alu_res = $signed(bus.SrcB) >>> bus.shamt;
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      4'd10:   alu_res = bus.SrcB << (WIDTH/2);
      default: alu_res = '0;
    endcase
  end

  assign bus.ALUResult   = alu_res;
  assign bus.Zero        = (bus.SrcA == bus.SrcB);
  assign bus.LessZero    = bus.SrcA[WIDTH-1];
  assign bus.GreaterZero = ~bus.SrcA[WIDTH-1] & (bus.SrcA != '0);

  // ---------------- MDU ----------------
  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [2:0]       op_reg, op_next;

  logic [2*WIDTH-1:0] prod_u, prod_s, mdu_res;
  logic               div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;

  // Result of the latched operation, evaluated against HI/LO as they stand at completion.
  // Division works on magnitudes so signed MIN / -1 falls out as LO=MIN, HI=0.
  always_comb begin
    prod_u     = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
    prod_s     = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    div_signed = (op_reg == OP_DIV);
    a_neg      = div_signed & a_reg[WIDTH-1];
    b_neg      = div_signed & b_reg[WIDTH-1];
    a_mag      = a_neg ? -a_reg : a_reg;
    b_mag      = b_neg ? -b_reg : b_reg;
    b_safe     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    q_res      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_res      = a_neg ? -r_mag : r_mag;
    mdu_res    = {hi_reg, lo_reg};
    case (op_reg)
      OP_MULTU: mdu_res = prod_u;
      OP_MULT:  mdu_res = prod_s;
      OP_DIVU, OP_DIV: begin
        if (b_reg == '0) mdu_res = {a_reg, {WIDTH{1'b1}}};
        else             mdu_res = {r_res, q_res};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  mdu_res = {hi_reg, lo_reg} + prod_s;
      OP_MSUB:  mdu_res = {hi_reg, lo_reg} - prod_s;
`endif
      default:  mdu_res = {hi_reg, lo_reg};
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          case (bus.MDUOp)
            OP_MULTU, OP_MULT
`ifdef MDU_MADD_EN
            , OP_MADD, OP_MSUB
`endif
            : begin
              state_next = RUN;
              cnt_next   = CW'(MUL_CYCLES);
              a_next     = bus.SrcA;
              b_next     = bus.SrcB;
              op_next    = bus.MDUOp;
            end
            OP_DIVU, OP_DIV: begin
              state_next = RUN;
              cnt_next   = CW'(DIV_CYCLES);
              a_next     = bus.SrcA;
              b_next     = bus.SrcB;
              op_next    = bus.MDUOp;
            end
            OP_MTHI: hi_next = bus.SrcA;
            OP_MTLO: lo_next = bus.SrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_reg == CW'(1)) begin
          state_next         = IDLE;
          cnt_next           = '0;
          {hi_next, lo_next} = mdu_res;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
    end
  end

  assign bus.Busy = (state_reg == RUN);
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: ALU vector table plus hand-written MDU sequences.
// MDU_MADD_EN selects which madd/msub expectations apply.
module tb_alu_mdu;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  alu_mdu_if #(.WIDTH(32)) bus ();

  alu_mdu #(
    .WIDTH(32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        gz;
    logic        lz;
  } alu_vec_t;

  alu_vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one MDU op, count Busy cycles (optionally poking a Start mid-flight),
  // check HI/LO hold their prior value while busy, then check final values.
  task automatic run_mdu(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_busy, input logic [31:0] pre_hi,
                         input logic [31:0] pre_lo, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int pulse_at);
    int busy_cycles;
    busy_cycles = 0;
    bus.Start = 1'b1;
    bus.MDUOp = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(negedge clk);
    bus.Start = 1'b0;
    while (bus.Busy && busy_cycles < 40) begin
      busy_cycles++;
      check({name, " hi held"}, bus.HI, pre_hi);
      check({name, " lo held"}, bus.LO, pre_lo);
      if (busy_cycles == pulse_at) begin
        bus.Start = 1'b1;
        bus.MDUOp = 3'd4;
        bus.SrcA  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      bus.Start = 1'b0;
    end
    check({name, " busy cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({name, " hi"}, bus.HI, exp_hi);
    check({name, " lo"}, bus.LO, exp_lo);
    $display("%s a=%h b=%h busy=%0d hi=%h lo=%h", name, a, b, busy_cycles, bus.HI, bus.LO);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n        = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.ALUControl = '0;
    bus.shamt      = '0;
    bus.Start      = 1'b0;
    bus.MDUOp      = '0;

    vecs[0]  = '{32'hFFFF_FFF0, 32'h0000_0010, 4'd0,  5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'hFFFF_FFF0, 32'h0000_0010, 4'd8,  5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'hFFFF_FFF0, 32'h0000_0010, 4'd9,  5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'hFFFF_FFF0, 32'h8000_0000, 4'd7,  5'd4,  32'hF800_0000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0005, 4'd1,  5'd0,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_F0F0, 32'h0000_FF00, 4'd2,  5'd0,  32'h0000_0FF0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_F0F0, 32'h0000_0F00, 4'd3,  5'd0,  32'h0000_FFF0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_F0F0, 32'h0000_FF00, 4'd4,  5'd0,  32'h0000_F000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0001, 4'd5,  5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h8000_0000, 4'd6,  5'd4,  32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0000, 32'h0000_1234, 4'd10, 5'd0,  32'h1234_0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0007, 32'h0000_0003, 4'd11, 5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_0000, 32'h0000_0001, 4'd1,  5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.Busy), 32'd0);
    check("reset hi", bus.HI, 32'h0);
    check("reset lo", bus.LO, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.SrcA       = vecs[i].a;
      bus.SrcB       = vecs[i].b;
      bus.ALUControl = vecs[i].ctl;
      bus.shamt      = vecs[i].sh;
      #1;
      check($sformatf("alu[%0d] result", i), bus.ALUResult, vecs[i].res);
      check($sformatf("alu[%0d] zero", i), 32'(bus.Zero), 32'(vecs[i].zero));
      check($sformatf("alu[%0d] gz", i), 32'(bus.GreaterZero), 32'(vecs[i].gz));
      check($sformatf("alu[%0d] lz", i), 32'(bus.LessZero), 32'(vecs[i].lz));
      $display("alu op=%0d a=%h b=%h sh=%0d res=%h", vecs[i].ctl, vecs[i].a, vecs[i].b,
               vecs[i].sh, bus.ALUResult);
    end

    @(negedge clk);
    run_mdu("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'h0, 32'h0,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
    run_mdu("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_mdu("divu by zero", 3'd2, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
            32'h0000_0007, 32'hFFFF_FFFF, 0);
    run_mdu("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h7, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h8000_0000, 0);
    run_mdu("multu", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0, 32'h8000_0000,
            32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_mdu("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFE, 32'h1,
            32'h0000_0001, 32'hFFFF_FFFD, 0);

    // mthi then mtlo on consecutive edges
    bus.Start = 1'b1;
    bus.MDUOp = 3'd4;
    bus.SrcA  = 32'h1234;
    @(negedge clk);
    check("mthi busy", 32'(bus.Busy), 32'd0);
    check("mthi hi", bus.HI, 32'h1234);
    bus.MDUOp = 3'd5;
    bus.SrcA  = 32'h5678;
    @(negedge clk);
    bus.Start = 1'b0;
    check("mtlo busy", 32'(bus.Busy), 32'd0);
    check("mtlo hi", bus.HI, 32'h1234);
    check("mtlo lo", bus.LO, 32'h5678);
    $display("mthi/mtlo hi=%h lo=%h busy=%0d", bus.HI, bus.LO, bus.Busy);

    // reset in cycle 3 of a divide
    bus.Start = 1'b1;
    bus.MDUOp = 3'd3;
    bus.SrcA  = 32'hFFFF_FFF9;
    bus.SrcB  = 32'd2;
    @(negedge clk);
    bus.Start = 1'b0;
    check("abort busy before", 32'(bus.Busy), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort busy", 32'(bus.Busy), 32'd0);
    check("abort hi", bus.HI, 32'h0);
    check("abort lo", bus.LO, 32'h0);
    repeat (15) @(negedge clk);
    check("abort late busy", 32'(bus.Busy), 32'd0);
    check("abort late hi", bus.HI, 32'h0);
    check("abort late lo", bus.LO, 32'h0);
    $display("div aborted by reset hi=%h lo=%h", bus.HI, bus.LO);

    // madd/msub on HI:LO = 0:10
    bus.Start = 1'b1;
    bus.MDUOp = 3'd5;
    bus.SrcA  = 32'd10;
    @(negedge clk);
    bus.Start = 1'b0;
`ifdef MDU_MADD_EN
    run_mdu("madd", 3'd6, 32'd2, 32'd3, 5, 32'h0, 32'd10, 32'h0, 32'd16, 0);
    run_mdu("msub", 3'd7, 32'd2, 32'd5, 5, 32'h0, 32'd16, 32'h0, 32'd6, 0);
    run_mdu("msub borrow", 3'd7, 32'd1, 32'd7, 5, 32'h0, 32'd6,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`else
    run_mdu("madd off", 3'd6, 32'd2, 32'd3, 0, 32'h0, 32'd10, 32'h0, 32'd10, 0);
    run_mdu("msub off", 3'd7, 32'd2, 32'd5, 0, 32'h0, 32'd10, 32'h0, 32'd10, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
